// File: rtl/fnn_ctrl_pkg.sv
// Shared types and helpers for the fully connected layer controller.
package fnn_ctrl_pkg;
  typedef enum logic [1:0] {FILL, BURST, WAIT, DRAIN} state_t;

  localparam int WORD_W = 16;
  typedef logic [WORD_W-1:0] word_t;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/fnn_result_collect.sv
// Per-neuron result capture: flags, result registers, all-captured detect, drain mux.
// Latency: capture on the cycle after a pulse; all_done includes same-cycle pulses.
// Backpressure: none; sel is held by the parent while downstream stalls.
module fnn_result_collect #(
  parameter int NUM_NEURONS = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int SEL_W       = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              capture_en,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] n_out_data,
  input  logic [NUM_NEURONS-1:0]            n_out_valid,
  input  logic [SEL_W-1:0]                  sel,
  output logic                              all_done,
  output logic [DATA_WIDTH-1:0]             rd_data
);
  logic [NUM_NEURONS-1:0] flags;
  logic [DATA_WIDTH-1:0]  result [NUM_NEURONS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags <= '0;
      for (int k = 0; k < NUM_NEURONS; k++) result[k] <= '0;
    end else if (clear) begin
      flags <= '0;
    end else if (capture_en) begin
      for (int k = 0; k < NUM_NEURONS; k++) begin
        if (n_out_valid[k]) begin
          flags[k]  <= 1'b1;
          result[k] <= n_out_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign all_done = capture_en && (&(flags | n_out_valid));

  // Neurons that never reported drain as zero, not as a stale value.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_NEURONS; k++) begin
      if (int'(sel) == k && flags[k]) rd_data = result[k];
    end
  end
endmodule

// File: rtl/fnn_layer_ctrl.sv
// Layer sequencer: buffer an input vector, broadcast it gap-free, collect and serialise results.
// Latency: first broadcast word 2 cycles after the final input transfer.
// Backpressure: in_ready low outside FILL; drain holds out_data while out_ready is low.
module fnn_layer_ctrl import fnn_ctrl_pkg::*; #(
  parameter int NUM_INPUTS   = 10,
  parameter int NUM_NEURONS  = 10,
  parameter int DATA_WIDTH   = 16,
  parameter int WAIT_TIMEOUT = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [DATA_WIDTH-1:0]             n_in_data,
  output logic                              n_in_valid,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] n_out_data,
  input  logic [NUM_NEURONS-1:0]            n_out_valid,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              busy,
  output logic                              timeout_err
);
  localparam int IN_W  = cnt_w(NUM_INPUTS);
  localparam int OUT_W = cnt_w(NUM_NEURONS);
  localparam int WT_W  = cnt_w(WAIT_TIMEOUT);

  state_t                state;
  logic [DATA_WIDTH-1:0] in_buf [NUM_INPUTS];
  logic [DATA_WIDTH-1:0] buf_rd;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [IN_W-1:0]       in_cnt;
  logic [IN_W-1:0]       b_cnt;
  logic [OUT_W-1:0]      o_cnt;
  logic [WT_W-1:0]       w_cnt;
  logic                  xfer;
  logic                  burst_done;
  logic                  all_done;

  assign xfer       = in_valid && in_ready;
  assign burst_done = (state == BURST) && (b_cnt == IN_W'(NUM_INPUTS));

  always_comb begin
    buf_rd = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (int'(b_cnt) == i) buf_rd = in_buf[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FILL;
      in_cnt      <= '0;
      b_cnt       <= '0;
      o_cnt       <= '0;
      w_cnt       <= '0;
      in_ready    <= 1'b0;
      n_in_valid  <= 1'b0;
      n_in_data   <= '0;
      out_valid   <= 1'b0;
      timeout_err <= 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++) in_buf[i] <= '0;
    end else begin
      case (state)
        FILL: begin
          in_ready <= 1'b1;
          if (xfer) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
              if (int'(in_cnt) == i) in_buf[i] <= in_data;
            end
            if (in_cnt == IN_W'(NUM_INPUTS - 1)) begin
              in_cnt   <= '0;
              in_ready <= 1'b0;
              state    <= BURST;
            end else begin
              in_cnt <= in_cnt + 1'b1;
            end
          end
        end
        BURST: begin
          // Never stall mid-burst: a gap would make the neurons apply bias early.
          if (burst_done) begin
            n_in_valid <= 1'b0;
            n_in_data  <= '0;
            b_cnt      <= '0;
            w_cnt      <= '0;
            state      <= WAIT;
          end else begin
            n_in_valid <= 1'b1;
            n_in_data  <= buf_rd;
            b_cnt      <= b_cnt + 1'b1;
          end
        end
        WAIT: begin
          if (all_done) begin
            out_valid <= 1'b1;
            state     <= DRAIN;
          end else if (w_cnt == WT_W'(WAIT_TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            out_valid   <= 1'b1;
            state       <= DRAIN;
          end else begin
            w_cnt <= w_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (o_cnt == OUT_W'(NUM_NEURONS - 1)) begin
              o_cnt     <= '0;
              out_valid <= 1'b0;
              in_ready  <= 1'b1;
              state     <= FILL;
            end else begin
              o_cnt <= o_cnt + 1'b1;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  fnn_result_collect #(
    .NUM_NEURONS (NUM_NEURONS),
    .DATA_WIDTH  (DATA_WIDTH),
    .SEL_W       (OUT_W)
  ) u_collect (
    .clk         (clk),
    .rst         (rst),
    .clear       (burst_done),
    .capture_en  (state == WAIT),
    .n_out_data  (n_out_data),
    .n_out_valid (n_out_valid),
    .sel         (o_cnt),
    .all_done    (all_done),
    .rd_data     (rd_data)
  );

  assign out_data = out_valid ? rd_data : '0;
  assign busy     = (state != FILL) || (in_cnt != '0);
endmodule

// File: tb/tb_fnn_layer_ctrl.sv
// Scoreboard bench for fnn_layer_ctrl with a behavioural neuron array.
module tb_fnn_layer_ctrl;
  import fnn_ctrl_pkg::*;

  localparam int NI = 4;
  localparam int NN = 3;
  localparam int DW = 16;
  localparam int WT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [DW-1:0]     in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     n_in_data;
  logic              n_in_valid;
  logic [NN*DW-1:0]  n_out_data;
  logic [NN-1:0]     n_out_valid;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              timeout_err;

  always #5 clk = ~clk;

  fnn_layer_ctrl #(
    .NUM_INPUTS   (NI),
    .NUM_NEURONS  (NN),
    .DATA_WIDTH   (DW),
    .WAIT_TIMEOUT (WT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .n_in_data   (n_in_data),
    .n_in_valid  (n_in_valid),
    .n_out_data  (n_out_data),
    .n_out_valid (n_out_valid),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  int    checks = 0;
  int    passes = 0;
  int    cyc = 0;
  word_t bq[$];
  word_t sq[$];
  int    dly[NN];
  bit    never[NN];
  bit    chk_lat = 1'b0;
  int    last_pulse_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  always @(posedge clk) cyc++;

  // Neuron array: accumulate the burst, then pulse sum+k after dly[k] cycles.
  word_t sum;
  bit    acc;
  bit    pend[NN];
  int    cnt[NN];
  always @(negedge clk) begin
    if (rst) begin
      n_out_valid = '0;
      n_out_data  = '0;
      acc = 1'b0;
      sum = '0;
      for (int k = 0; k < NN; k++) pend[k] = 1'b0;
    end else begin
      n_out_valid = '0;
      for (int k = 0; k < NN; k++) begin
        if (pend[k]) begin
          if (cnt[k] == 0) begin
            n_out_valid[k] = 1'b1;
            n_out_data[k*DW +: DW] = sum + word_t'(k);
            pend[k] = 1'b0;
            last_pulse_cyc = cyc;
          end else begin
            cnt[k]--;
          end
        end
      end
      if (n_in_valid) begin
        if (!acc) sum = '0;
        acc = 1'b1;
        sum = sum + n_in_data;
      end else if (acc) begin
        acc = 1'b0;
        for (int k = 0; k < NN; k++) begin
          if (!never[k]) begin
            pend[k] = 1'b1;
            cnt[k]  = dly[k];
          end
        end
      end
    end
  end

  // Monitor: broadcast words, burst length, drained words, stall stability.
  bit prev_niv = 1'b0;
  bit prev_ov  = 1'b0;
  int run = 0;
  always @(negedge clk) begin
    if (rst) begin
      run = 0;
      prev_niv = 1'b0;
      prev_ov = 1'b0;
    end else begin
      if (n_in_valid) begin
        run++;
        if (bq.size() == 0) chk("burst_unexpected", 1, 0);
        else chk("burst_word", n_in_data, bq.pop_front());
      end else if (prev_niv) begin
        chk("burst_len", run, NI);
        run = 0;
      end
      prev_niv = n_in_valid;
      if (out_valid) begin
        if (sq.size() == 0) chk("out_unexpected", 1, 0);
        else if (out_ready) chk("out_word", out_data, sq.pop_front());
        else chk("out_stall_hold", out_data, sq[0]);
      end
      if (out_valid && !prev_ov && chk_lat) chk("drain_entry_lat", cyc - last_pulse_cyc, 1);
      prev_ov = out_valid;
    end
  end

  task automatic push_word(input word_t w);
    int t = 0;
    bit got = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    while (!got) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      t++;
      if (!got && t > 200) begin
        chk("in_ready_timeout", 0, 1);
        got = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input word_t a, input word_t b, input word_t c, input word_t d,
                          input bit toggle, input bit exp_out);
    word_t v[NI];
    word_t s;
    v = '{a, b, c, d};
    s = a + b + c + d;
    for (int i = 0; i < NI; i++) bq.push_back(v[i]);
    if (exp_out) begin
      for (int k = 0; k < NN; k++) sq.push_back(never[k] ? word_t'(0) : s + word_t'(k));
    end
    for (int i = 0; i < NI; i++) begin
      push_word(v[i]);
      if (toggle) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (sq.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) chk({name, "_drain_timeout"}, 0, 1);
    @(negedge clk);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_out_valid"}, out_valid, 0);
    chk({name, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1;
    bq.delete();
    sq.delete();
    #1;
    chk({name, "_in_ready"}, in_ready, 0);
    chk({name, "_n_in_valid"}, n_in_valid, 0);
    chk({name, "_n_in_data"}, n_in_data, 0);
    chk({name, "_out_valid"}, out_valid, 0);
    chk({name, "_out_data"}, out_data, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_timeout_err"}, timeout_err, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_out_valid();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!out_valid && t < 300);
    if (!out_valid) chk("out_valid_timeout", 0, 1);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    n_out_valid = '0;
    n_out_data = '0;
    for (int k = 0; k < NN; k++) begin
      dly[k] = 8;
      never[k] = 1'b0;
    end
    @(posedge clk);
    #1;
    do_reset("init");

    send_vec(1, 2, 3, 4, 1'b0, 1'b1);
    wait_idle("basic");

    send_vec(5, 6, 7, 8, 1'b1, 1'b1);
    wait_idle("toggle");

    dly = '{6, 6, 2};
    chk_lat = 1'b1;
    send_vec(2, 3, 4, 5, 1'b0, 1'b1);
    wait_idle("stagger");
    chk_lat = 1'b0;
    dly = '{8, 8, 8};

    never[1] = 1'b1;
    send_vec(2, 4, 6, 8, 1'b0, 1'b1);
    n = 0;
    while (!n_in_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (n_in_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!timeout_err && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_lat", n, WT);
    wait_idle("timeout");
    never[1] = 1'b0;
    send_vec(1, 1, 1, 1, 1'b0, 1'b1);
    wait_idle("after_timeout");
    chk("timeout_sticky", timeout_err, 1);

    send_vec(3, 3, 3, 3, 1'b0, 1'b1);
    wait_out_valid();
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle("stall");

    push_word(7);
    push_word(7);
    do_reset("midfill");
    send_vec(1, 2, 3, 4, 1'b0, 1'b1);
    wait_idle("post_midfill");

    send_vec(9, 9, 9, 9, 1'b0, 1'b0);
    n = 0;
    while (!n_in_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    do_reset("midburst");
    send_vec(2, 2, 2, 3, 1'b0, 1'b1);
    wait_idle("post_midburst");

    chk("scoreboard_empty", sq.size() + bq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end
endmodule
